// File: rtl/bilinear_coord_gen.sv
// Raster-order source-coordinate generator for the bilinear interpolation PE.
// Emits a clamped fixed-point sample position plus four neighbour addresses per output pixel.
module bilinear_coord_gen #(
    parameter int AWIDTH = 11,
    parameter int EXTEND = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [AWIDTH-1:0]        in_width,
    input  logic [AWIDTH-1:0]        in_height,
    input  logic [AWIDTH-1:0]        out_width,
    input  logic [AWIDTH-1:0]        out_height,
    input  logic [AWIDTH+EXTEND-1:0] step_col,
    input  logic [AWIDTH+EXTEND-1:0] step_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AWIDTH+EXTEND-1:0] index_row,
    output logic [AWIDTH+EXTEND-1:0] index_col,
    output logic [AWIDTH+EXTEND-1:0] index_row_origin,
    output logic [AWIDTH+EXTEND-1:0] index_col_origin,
    output logic [AWIDTH-1:0]        rd_row0,
    output logic [AWIDTH-1:0]        rd_row1,
    output logic [AWIDTH-1:0]        rd_col0,
    output logic [AWIDTH-1:0]        rd_col1,
    output logic                     last_col,
    output logic                     last_frame,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = AWIDTH + EXTEND;
    localparam int AW = CW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [AWIDTH-1:0] in_width_reg, in_width_next, in_height_reg, in_height_next;
    logic [AWIDTH-1:0] out_width_reg, out_width_next, out_height_reg, out_height_next;
    logic [CW-1:0]     step_col_reg, step_col_next, step_row_reg, step_row_next;
    logic [AWIDTH-1:0] r_reg, r_next, c_reg, c_next;
    logic [AW-1:0]     row_acc_reg, row_acc_next, col_acc_reg, col_acc_next;
    logic              valid_next, done_next, last_col_next, last_frame_next;

    // Once the overflow MSB is set the accumulator sticks there, so it stays beyond the edge.
    function automatic logic [AW-1:0] acc_step(input logic [AW-1:0] acc, input logic [CW-1:0] step);
        return acc[AW-1] ? acc : acc + {1'b0, step};
    endfunction

    always_comb begin
        state_next      = state_reg;
        in_width_next   = in_width_reg;
        in_height_next  = in_height_reg;
        out_width_next  = out_width_reg;
        out_height_next = out_height_reg;
        step_col_next   = step_col_reg;
        step_row_next   = step_row_reg;
        r_next          = r_reg;
        c_next          = c_reg;
        row_acc_next    = row_acc_reg;
        col_acc_next    = col_acc_reg;
        valid_next      = out_valid;
        done_next       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    in_width_next   = in_width;
                    in_height_next  = in_height;
                    out_width_next  = out_width;
                    out_height_next = out_height;
                    step_col_next   = step_col;
                    step_row_next   = step_row;
                    r_next          = '0;
                    c_next          = '0;
                    row_acc_next    = '0;
                    col_acc_next    = '0;
                    if (out_width != '0 && out_height != '0) begin
                        state_next = ST_RUN;
                        valid_next = 1'b1;
                    end else begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (out_valid && out_ready) begin
                    if (last_frame) begin
                        state_next = ST_DONE;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else if (last_col) begin
                        c_next       = '0;
                        col_acc_next = '0;
                        r_next       = r_reg + AWIDTH'(1);
                        row_acc_next = acc_step(row_acc_reg, step_row_reg);
                    end else begin
                        c_next       = c_reg + AWIDTH'(1);
                        col_acc_next = acc_step(col_acc_reg, step_col_reg);
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign last_col_next   = (c_next == out_width_next - AWIDTH'(1));
    assign last_frame_next = last_col_next && (r_next == out_height_next - AWIDTH'(1));

    // Axis 0 is the row axis, axis 1 the column axis; both clamp identically.
    logic [AW-1:0]     axis_acc  [2];
    logic [AWIDTH-1:0] axis_size [2];
    logic [AWIDTH-1:0] axis_last [2];
    logic              axis_clamp[2];
    logic [CW-1:0]     axis_pos  [2];
    logic [AWIDTH-1:0] axis_rd0  [2];
    logic [AWIDTH-1:0] axis_rd1  [2];

    assign axis_acc[0]  = row_acc_next;
    assign axis_acc[1]  = col_acc_next;
    assign axis_size[0] = in_height_next;
    assign axis_size[1] = in_width_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            assign axis_last[gi]  = axis_size[gi] - AWIDTH'(1);
            assign axis_clamp[gi] = axis_acc[gi][AW-1] || (axis_acc[gi][CW-1:EXTEND] >= axis_last[gi]);
            assign axis_pos[gi]   = axis_clamp[gi] ? {axis_last[gi], {EXTEND{1'b0}}} : axis_acc[gi][CW-1:0];
            assign axis_rd0[gi]   = axis_clamp[gi] ? axis_last[gi] : axis_acc[gi][CW-1:EXTEND];
            assign axis_rd1[gi]   = axis_clamp[gi] ? axis_last[gi] : axis_acc[gi][CW-1:EXTEND] + AWIDTH'(1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            in_width_reg     <= '0;
            in_height_reg    <= '0;
            out_width_reg    <= '0;
            out_height_reg   <= '0;
            step_col_reg     <= '0;
            step_row_reg     <= '0;
            r_reg            <= '0;
            c_reg            <= '0;
            row_acc_reg      <= '0;
            col_acc_reg      <= '0;
            out_valid        <= 1'b0;
            done             <= 1'b0;
            busy             <= 1'b0;
            index_row        <= '0;
            index_col        <= '0;
            index_row_origin <= '0;
            index_col_origin <= '0;
            rd_row0          <= '0;
            rd_row1          <= '0;
            rd_col0          <= '0;
            rd_col1          <= '0;
            last_col         <= 1'b0;
            last_frame       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            in_width_reg     <= in_width_next;
            in_height_reg    <= in_height_next;
            out_width_reg    <= out_width_next;
            out_height_reg   <= out_height_next;
            step_col_reg     <= step_col_next;
            step_row_reg     <= step_row_next;
            r_reg            <= r_next;
            c_reg            <= c_next;
            row_acc_reg      <= row_acc_next;
            col_acc_reg      <= col_acc_next;
            out_valid        <= valid_next;
            done             <= done_next;
            busy             <= (state_next != ST_IDLE);
            index_row        <= axis_pos[0];
            index_col        <= axis_pos[1];
            index_row_origin <= {axis_pos[0][CW-1:EXTEND], {EXTEND{1'b0}}};
            index_col_origin <= {axis_pos[1][CW-1:EXTEND], {EXTEND{1'b0}}};
            rd_row0          <= axis_rd0[0];
            rd_row1          <= axis_rd1[0];
            rd_col0          <= axis_rd0[1];
            rd_col1          <= axis_rd1[1];
            last_col         <= last_col_next;
            last_frame       <= last_frame_next;
        end
    end
endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Bench for bilinear_coord_gen: table of frame configs, queue scoreboard fed from a
// multiplication-based reference, spot vectors from hand-worked examples, plus reset/stall sequences.
module tb_bilinear_coord_gen;
    localparam int AW = 11;
    localparam int EX = 30;
    localparam int CW = AW + EX;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] in_width, in_height, out_width, out_height;
    logic [CW-1:0] step_col, step_row;
    logic          out_valid, out_ready;
    logic [CW-1:0] index_row, index_col, index_row_origin, index_col_origin;
    logic [AW-1:0] rd_row0, rd_row1, rd_col0, rd_col1;
    logic          last_col, last_frame, busy, done;

    bilinear_coord_gen #(.AWIDTH(AW), .EXTEND(EX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_width(in_width), .in_height(in_height),
        .out_width(out_width), .out_height(out_height),
        .step_col(step_col), .step_row(step_row),
        .out_valid(out_valid), .out_ready(out_ready),
        .index_row(index_row), .index_col(index_col),
        .index_row_origin(index_row_origin), .index_col_origin(index_col_origin),
        .rd_row0(rd_row0), .rd_row1(rd_row1), .rd_col0(rd_col0), .rd_col1(rd_col1),
        .last_col(last_col), .last_frame(last_frame), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [CW-1:0] ir, ic, iro, ico;
        logic [AW-1:0] rr0, rr1, rc0, rc1;
        logic          lc, lf;
    } beat_t;

    typedef struct {
        int            iw, ih, ow, oh;
        logic [CW-1:0] sc, sr;
        int            rmode;
        bit            midstart;
    } cfg_t;

    typedef struct {
        int    cfg, r, c;
        beat_t b;
    } spot_t;

    cfg_t  cfgs[9];
    spot_t spots[8];
    beat_t exp_q[$];
    beat_t dut_beat;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_accept_cyc = 0, beats = 0, done_cnt = 0, spot_hits = 0;
    int mon_r = 0, mon_c = 0, cur_id = 0, rmode = 0, stall_left = 0;
    bit mon_en = 0;
    cfg_t cur;

    assign dut_beat = {index_row, index_col, index_row_origin, index_col_origin,
                       rd_row0, rd_row1, rd_col0, rd_col1, last_col, last_frame};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic beat_t mk_beat(input logic [CW-1:0] ir, ic, iro, ico,
                                      input int rr0, rr1, rc0, rc1, input bit lc, lf);
        beat_t b;
        b.ir = ir; b.ic = ic; b.iro = iro; b.ico = ico;
        b.rr0 = AW'(rr0); b.rr1 = AW'(rr1); b.rc0 = AW'(rc0); b.rc1 = AW'(rc1);
        b.lc = lc; b.lf = lf;
        return b;
    endfunction

    function automatic void axis(input logic [63:0] acc, input int size,
                                 output logic [CW-1:0] pos, output logic [AW-1:0] r0, output logic [AW-1:0] r1);
        logic [63:0] ip;
        ip = acc >> EX;
        if (ip >= 64'(size - 1)) begin
            pos = CW'(size - 1) << EX;
            r0  = AW'(size - 1);
            r1  = AW'(size - 1);
        end else begin
            pos = acc[CW-1:0];
            r0  = ip[AW-1:0];
            r1  = AW'(ip + 64'd1);
        end
    endfunction

    function automatic beat_t model(input cfg_t c, input int r, input int cc);
        beat_t b;
        logic [CW-1:0] mask;
        mask = (CW'(1) << EX) - CW'(1);
        axis(64'(r) * 64'(c.sr), c.ih, b.ir, b.rr0, b.rr1);
        axis(64'(cc) * 64'(c.sc), c.iw, b.ic, b.rc0, b.rc1);
        b.iro = b.ir & ~mask;
        b.ico = b.ic & ~mask;
        b.lc  = (cc == c.ow - 1);
        b.lf  = b.lc && (r == c.oh - 1);
        return b;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer ready: always-ready, or random with a forced 5-cycle stall on pixel (1,1).
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            if (rmode == 0) out_ready = 1;
            else if (mon_r == 1 && mon_c == 1 && stall_left > 0) begin
                out_ready = 0;
                stall_left--;
            end else out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard pop on every accepted beat, hold check across stalls.
    initial begin
        bit    stall_pend;
        beat_t stall_snap, e;
        stall_pend = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                stall_pend = 0;
            end else begin
                if (stall_pend) begin
                    chk("stall_valid_held", 256'(out_valid), 256'(1));
                    chk("stall_data_held", 256'(dut_beat), 256'(stall_snap));
                end
                stall_pend = out_valid && !out_ready;
                stall_snap = dut_beat;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 256'(dut_beat), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("beat_cfg%0d_r%0d_c%0d", cur_id, mon_r, mon_c), 256'(dut_beat), 256'(e));
                    end
                    foreach (spots[k]) begin
                        if (spots[k].cfg == cur_id && spots[k].r == mon_r && spots[k].c == mon_c) begin
                            chk($sformatf("spot%0d", k), 256'(dut_beat), 256'(spots[k].b));
                            spot_hits++;
                        end
                    end
                    last_accept_cyc = cyc;
                    beats++;
                    if (mon_c == cur.ow - 1) begin
                        mon_c = 0;
                        mon_r++;
                    end else mon_c++;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic drive_cfg(input cfg_t c);
        in_width   = AW'(c.iw);
        in_height  = AW'(c.ih);
        out_width  = AW'(c.ow);
        out_height = AW'(c.oh);
        step_col   = c.sc;
        step_row   = c.sr;
    endtask

    task automatic drive_garbage();
        in_width = 1; in_height = 1; out_width = 2; out_height = 1;
        step_col = '0; step_row = '0;
    endtask

    task automatic launch(input int id);
        cur_id = id; cur = cfgs[id]; rmode = cur.rmode;
        mon_r = 0; mon_c = 0; beats = 0; done_cnt = 0; stall_left = 5;
        if (cur.ow > 0 && cur.oh > 0)
            for (int r = 0; r < cur.oh; r++)
                for (int c = 0; c < cur.ow; c++)
                    exp_q.push_back(model(cur, r, c));
        @(negedge clk);
        drive_cfg(cur);
        start = 1;
        @(negedge clk);
        start = 0;
        drive_garbage();
    endtask

    task automatic run_frame(input int id);
        bit got;
        bit nz;
        launch(id);
        nz = (cur.ow > 0 && cur.oh > 0);
        chk($sformatf("cfg%0d_first_valid", id), 256'(out_valid), 256'(nz));
        chk($sformatf("cfg%0d_busy", id), 256'(busy), 256'(1));
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (cur.midstart && i == 4) begin
                start = 1;
            end
            if (cur.midstart && i == 5) start = 0;
            @(negedge clk);
        end
        start = 0;
        chk($sformatf("cfg%0d_done_seen", id), 256'(got), 256'(1));
        if (nz) chk($sformatf("cfg%0d_done_latency", id), 256'(cyc), 256'(last_accept_cyc + 1));
        else chk($sformatf("cfg%0d_no_beats", id), 256'(beats), 256'(0));
        chk($sformatf("cfg%0d_valid_at_done", id), 256'(out_valid), 256'(0));
        chk($sformatf("cfg%0d_beats", id), 256'(beats), 256'(nz ? cur.ow * cur.oh : 0));
        chk($sformatf("cfg%0d_queue_empty", id), 256'(exp_q.size()), 256'(0));
        @(negedge clk);
        chk($sformatf("cfg%0d_done_one_cycle", id), 256'(done), 256'(0));
        chk($sformatf("cfg%0d_idle_busy", id), 256'(busy), 256'(0));
        chk($sformatf("cfg%0d_done_count", id), 256'(done_cnt), 256'(1));
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit got;
        //             iw  ih  ow oh  step_col               step_row     mode mid
        cfgs[0] = '{8, 6, 4, 3, 41'd2 << 30, 41'd2 << 30, 0, 0};
        cfgs[1] = '{8, 8, 4, 4, 41'd3 << 29, 41'd3 << 29, 0, 0};
        cfgs[2] = '{5, 5, 4, 2, 41'd3 << 29, 41'd1 << 30, 0, 0};
        cfgs[3] = '{8, 6, 4, 3, 41'd2 << 30, 41'd2 << 30, 1, 0};
        cfgs[4] = '{8, 6, 0, 3, 41'd2 << 30, 41'd2 << 30, 0, 0};
        cfgs[5] = '{16, 4, 5, 2, 41'h1FF_FFFF_FFFF, 41'd1 << 30, 1, 0};
        cfgs[6] = '{8, 6, 4, 3, 41'd2 << 30, 41'd2 << 30, 0, 1};
        cfgs[7] = '{4, 4, 3, 0, 41'd1 << 30, 41'd1 << 30, 0, 0};
        cfgs[8] = '{1, 1, 2, 2, 41'd1 << 30, 41'd1 << 30, 1, 0};

        spots[0] = '{0, 1, 2, mk_beat(41'd2 << 30, 41'd4 << 30, 41'd2 << 30, 41'd4 << 30, 2, 3, 4, 5, 0, 0)};
        spots[1] = '{0, 2, 3, mk_beat(41'd4 << 30, 41'd6 << 30, 41'd4 << 30, 41'd6 << 30, 4, 5, 6, 7, 1, 1)};
        spots[2] = '{1, 0, 1, mk_beat(41'd0, 41'd3 << 29, 41'd0, 41'd1 << 30, 0, 1, 1, 2, 0, 0)};
        spots[3] = '{1, 0, 3, mk_beat(41'd0, 41'd9 << 29, 41'd0, 41'd4 << 30, 0, 1, 4, 5, 1, 0)};
        spots[4] = '{2, 0, 3, mk_beat(41'd0, 41'd4 << 30, 41'd0, 41'd4 << 30, 0, 1, 4, 4, 1, 0)};
        spots[5] = '{2, 1, 3, mk_beat(41'd1 << 30, 41'd4 << 30, 41'd1 << 30, 41'd4 << 30, 1, 2, 4, 4, 1, 1)};
        spots[6] = '{5, 0, 2, mk_beat(41'd0, 41'd15 << 30, 41'd0, 41'd15 << 30, 0, 1, 15, 15, 0, 0)};
        spots[7] = '{5, 1, 4, mk_beat(41'd1 << 30, 41'd15 << 30, 41'd1 << 30, 41'd15 << 30, 1, 2, 15, 15, 1, 1)};

        start = 0;
        drive_garbage();
        rst_n = 1;
        #3 rst_n = 0;
        #1;
        chk("reset_valid", 256'(out_valid), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_done", 256'(done), 256'(0));
        chk("reset_data", 256'(dut_beat), 256'(0));
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("idle_valid", 256'(out_valid), 256'(0));
        mon_en = 1;

        for (int i = 0; i < 9; i++) run_frame(i);
        chk("spot_hits", 256'(spot_hits), 256'(8));

        // Reset mid-frame once five beats have been accepted.
        launch(0);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (beats >= 5) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midreset_reach_beat5", 256'(got), 256'(1));
        @(posedge clk);
        #3;
        mon_en = 0;
        exp_q.delete();
        rst_n = 0;
        #1;
        chk("midreset_valid", 256'(out_valid), 256'(0));
        chk("midreset_busy", 256'(busy), 256'(0));
        chk("midreset_data", 256'(dut_beat), 256'(0));
        repeat (2) begin
            @(negedge clk);
            chk("midreset_no_done", 256'(done), 256'(0));
        end
        rst_n = 1;
        @(negedge clk);
        chk("postreset_no_done", 256'(done), 256'(0));
        chk("postreset_idle", 256'(busy), 256'(0));
        mon_en = 1;
        spot_hits = 0;
        run_frame(0);
        chk("postreset_spot_hits", 256'(spot_hits), 256'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
